croc_obi_reg_bridge: RTL and testbench

//  OBI subordinate (responder) that terminates one croc crossbar/periph-demux OBI port and
//  re-issues each access as a single regbus (reg_req_t/reg_rsp_t) transaction.

---
 rtl/croc_pkg.sv | 54 +++++
 rtl/croc_obi_reg_bridge.sv | 101 ++++++++++
 tb/tb_croc_obi_reg_bridge.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/croc_pkg.sv
// Shared croc SoC bus types: subordinate-side OBI and regbus structs,
// plus the default watchdog limit for the OBI-to-regbus bridge.
package croc_pkg;

   localparam int unsigned RegBridgeTimeout = 255;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [2:0]  aid;
      logic [0:0]  a_optional;
   } sbr_obi_a_chan_t;

   typedef struct packed {
      sbr_obi_a_chan_t a;
      logic            req;
   } sbr_obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [2:0]  rid;
      logic        err;
      logic [0:0]  r_optional;
   } sbr_obi_r_chan_t;

   typedef struct packed {
      sbr_obi_r_chan_t r;
      logic            gnt;
      logic            rvalid;
   } sbr_obi_rsp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   typedef enum logic [1:0] {
      BR_IDLE   = 2'd0,
      BR_ACCESS = 2'd1,
      BR_RESP   = 2'd2
   } bridge_state_e;

endpackage

// File: rtl/croc_obi_reg_bridge.sv
// OBI subordinate that re-issues each access as one regbus transaction.
// One outstanding access; a peripheral that never answers is aborted by a watchdog.
module croc_obi_reg_bridge
   import croc_pkg::*;
#(
   parameter int unsigned TimeoutCycles = RegBridgeTimeout,
   parameter logic [31:0] ErrData       = 32'hBADC_AB1E
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  sbr_obi_req_t obi_req_i,
   output sbr_obi_rsp_t obi_rsp_o,
   output reg_req_t     reg_req_o,
   input  reg_rsp_t     reg_rsp_i
);

   localparam int unsigned     CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

   bridge_state_e   state_q, state_d;
   sbr_obi_a_chan_t a_q, a_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            gnt;
   logic            timeout;
   logic            unused_a_optional;

   assign unused_a_optional = a_q.a_optional[0];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      // The last permitted wait cycle is the one where the counter reads TimeoutCycles-1.
      timeout = (TimeoutCycles != 0) && (cnt_q == CntLast);

      unique case (state_q)
         BR_IDLE, BR_RESP: begin
            // Gating with rst_ni keeps gnt low while reset is held, independent of req.
            gnt     = obi_req_i.req & rst_ni;
            state_d = BR_IDLE;
            if (gnt) begin
               a_d     = obi_req_i.a;
               cnt_d   = '0;
               state_d = BR_ACCESS;
            end
         end
         BR_ACCESS: begin
            if (reg_rsp_i.ready) begin
               rdata_d = a_q.we ? 32'h0 : reg_rsp_i.rdata;
               err_d   = reg_rsp_i.error;
               state_d = BR_RESP;
            end else if (timeout) begin
               rdata_d = a_q.we ? 32'h0 : ErrData;
               err_d   = 1'b1;
               state_d = BR_RESP;
            end else if ((TimeoutCycles != 0) && (cnt_q != CntLast)) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = BR_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BR_IDLE;
         a_q     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign reg_req_o.valid = (state_q == BR_ACCESS);
   assign reg_req_o.addr  = a_q.addr;
   assign reg_req_o.write = a_q.we;
   assign reg_req_o.wdata = a_q.wdata;
   assign reg_req_o.wstrb = a_q.we ? a_q.be : 4'b0000;

   // The A-channel register is only overwritten at the end of RESP, so it still holds this rid.
   assign obi_rsp_o.gnt          = gnt;
   assign obi_rsp_o.rvalid       = (state_q == BR_RESP);
   assign obi_rsp_o.r.rdata      = rdata_q;
   assign obi_rsp_o.r.rid        = a_q.aid;
   assign obi_rsp_o.r.err        = err_q;
   assign obi_rsp_o.r.r_optional = 1'b0;

endmodule

// File: tb/tb_croc_obi_reg_bridge.sv
// Directed bench for croc_obi_reg_bridge: an OBI manager and a scripted regbus
// peripheral, with a scoreboard of expected responses popped on each rvalid.
module tb_croc_obi_reg_bridge;
   import croc_pkg::*;

   localparam int          T   = 8;
   localparam logic [31:0] ERR = 32'hBADC_AB1E;

   typedef struct {
      sbr_obi_a_chan_t a;
      int              exp_valid;
      logic [31:0]     exp_rdata;
      logic            exp_err;
      int              acc_valid;
      int              gnt_cycle;
   } txn_t;

   logic         clk;
   logic         rst_n;
   sbr_obi_req_t obi_req;
   sbr_obi_rsp_t obi_rsp;
   reg_req_t     reg_req;
   reg_rsp_t     reg_rsp;

   croc_obi_reg_bridge #(.TimeoutCycles(T), .ErrData(ERR)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .obi_req_i (obi_req),
      .obi_rsp_o (obi_rsp),
      .reg_req_o (reg_req),
      .reg_rsp_i (reg_rsp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL global_time_limit reached");
      $fatal(1, "simulation time limit");
   end

   int              n_checks = 0;
   int              n_fail   = 0;
   int              cycle    = 0;
   int              wait_cnt = 0;
   int              per_lat  = 0;
   bit              per_hang = 1'b0;
   logic [31:0]     per_rdata = '0;
   logic            per_err  = 1'b0;
   sbr_obi_a_chan_t req_q[$];
   txn_t            sb[$];
   int              gnt_log[$];

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [2:0] aid);
      sbr_obi_a_chan_t a;
      a.addr       = addr;
      a.we         = we;
      a.be         = be;
      a.wdata      = wdata;
      a.aid        = aid;
      a.a_optional = 1'($urandom_range(0, 1));
      req_q.push_back(a);
   endtask

   // One clock cycle: drive manager and peripheral at negedge, then observe and score.
   task automatic step();
      txn_t t;
      bit   to;
      @(negedge clk);
      cycle++;
      obi_req.req = (req_q.size() > 0);
      if (req_q.size() > 0) obi_req.a = req_q[0];
      reg_rsp.ready = reg_req.valid && !per_hang && (wait_cnt == per_lat);
      reg_rsp.rdata = reg_rsp.ready ? per_rdata : $urandom();
      reg_rsp.error = reg_rsp.ready & per_err;
      #1;
      if (reg_req.valid) begin
         if (sb.size() == 0) begin
            check("valid_without_txn", 1'b1, 1'b0);
         end else begin
            check("reg_addr",  reg_req.addr,  sb[0].a.addr);
            check("reg_write", reg_req.write, sb[0].a.we);
            check("reg_wdata", reg_req.wdata, sb[0].a.wdata);
            check("reg_wstrb", reg_req.wstrb, sb[0].a.we ? sb[0].a.be : 4'b0000);
            check("gnt_in_access", obi_rsp.gnt, 1'b0);
            check("valid_overrun", sb[0].acc_valid < sb[0].exp_valid, 1'b1);
            sb[0].acc_valid = sb[0].acc_valid + 1;
         end
         wait_cnt = reg_rsp.ready ? 0 : wait_cnt + 1;
      end else begin
         wait_cnt = 0;
      end
      if (obi_rsp.rvalid) begin
         if (sb.size() == 0) begin
            check("rvalid_without_txn", 1'b1, 1'b0);
         end else begin
            t = sb.pop_front();
            check("rsp_rdata",   obi_rsp.r.rdata, t.exp_rdata);
            check("rsp_rid",     obi_rsp.r.rid,   t.a.aid);
            check("rsp_err",     obi_rsp.r.err,   t.exp_err);
            check("rsp_ropt",    obi_rsp.r.r_optional, 1'b0);
            check("valid_cycles", t.acc_valid, t.exp_valid);
            check("req_to_rvalid", cycle - t.gnt_cycle, t.exp_valid + 1);
         end
      end
      if (obi_req.req && obi_rsp.gnt) begin
         check("gnt_while_busy", sb.size(), 0);
         to          = per_hang || (per_lat >= T);
         t.a         = req_q.pop_front();
         t.exp_valid = to ? T : per_lat + 1;
         t.exp_err   = to ? 1'b1 : per_err;
         t.exp_rdata = t.a.we ? 32'h0 : (to ? ERR : per_rdata);
         t.acc_valid = 0;
         t.gnt_cycle = cycle;
         sb.push_back(t);
         gnt_log.push_back(cycle);
      end
   endtask

   task automatic run(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (req_q.size() == 0 && sb.size() == 0) break;
         step();
      end
      check("run_completed", (req_q.size() == 0 && sb.size() == 0), 1'b1);
   endtask

   initial begin
      obi_req = '0;
      reg_rsp = '0;
      rst_n   = 1'b0;

      // Reset: every output field zero, even with req asserted.
      obi_req.req  = 1'b1;
      obi_req.a    = '1;
      #12;
      check("reset_obi_rsp", obi_rsp, '0);
      check("reset_reg_req", reg_req, '0);
      @(negedge clk);
      obi_req = '0;
      #1 rst_n = 1'b1;
      step();
      check("idle_no_rvalid", obi_rsp.rvalid, 1'b0);

      // Read with a two-cycle peripheral wait.
      per_lat = 2; per_rdata = 32'h1234_5678; per_err = 1'b0;
      push_req(32'h0300_5004, 1'b0, 4'hF, 32'h5555_AAAA, 3'd3);
      run(40);

      // Write answered in the first ACCESS cycle.
      per_lat = 0; per_rdata = 32'hFFFF_FFFF;
      push_req(32'h0300_1000, 1'b1, 4'b0011, 32'hCAFE_F00D, 3'd1);
      run(40);

      // Peripheral error on a read.
      per_err = 1'b1; per_rdata = 32'h0000_BEEF;
      push_req(32'h0300_2008, 1'b0, 4'hF, 32'h0, 3'd5);
      run(40);
      per_err = 1'b0;

      // Watchdog on a read and a write, then a normal access afterwards.
      per_hang = 1'b1;
      push_req(32'h0300_3000, 1'b0, 4'hF, 32'h0, 3'd2);
      run(40);
      push_req(32'h0300_3004, 1'b1, 4'b1100, 32'h0BAD_F00D, 3'd7);
      run(40);
      per_hang = 1'b0; per_rdata = 32'h0A0B_0C0D;
      push_req(32'h0300_3008, 1'b0, 4'hF, 32'h0, 3'd4);
      run(40);

      // Ready on the timeout cycle completes normally; one cycle later it is too late.
      per_lat = T - 1; per_rdata = 32'h7777_1111;
      push_req(32'h0300_4000, 1'b0, 4'hF, 32'h0, 3'd6);
      run(40);
      per_lat = T;
      push_req(32'h0300_4004, 1'b0, 4'hF, 32'h0, 3'd0);
      run(40);

      // Back-to-back reads with req held high.
      per_lat = 0; per_rdata = 32'h1357_9BDF;
      gnt_log.delete();
      for (int i = 0; i < 4; i++) push_req(32'h0300_6000 + 32'(i * 4), 1'b0, 4'hF, 32'h0, 3'(i));
      run(40);
      check("b2b_gnt_count", gnt_log.size(), 4);
      for (int i = 0; i + 1 < gnt_log.size(); i++)
         check("b2b_gnt_spacing", gnt_log[i + 1] - gnt_log[i], 2);

      // Reset asserted mid-ACCESS discards the pending response.
      per_hang = 1'b1;
      push_req(32'h0300_7000, 1'b0, 4'hF, 32'h0, 3'd6);
      push_req(32'h0300_7004, 1'b0, 4'hF, 32'h0, 3'd2);
      for (int i = 0; i < 20 && !reg_req.valid; i++) step();
      check("reached_access", reg_req.valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_valid_low",  reg_req.valid,  1'b0);
      check("rst_rvalid_low", obi_rsp.rvalid, 1'b0);
      check("rst_gnt_low",    obi_rsp.gnt,    1'b0);
      req_q.delete();
      sb.delete();
      per_hang = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      per_lat = 1; per_rdata = 32'h2468_ACE0;
      push_req(32'h0300_7008, 1'b0, 4'hF, 32'h0, 3'd1);
      run(40);
      step();
      check("final_idle", reg_req.valid | obi_rsp.rvalid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
